// File: rtl/fetch_unit_pkg.sv
// Shared constants and payload types for the instruction fetch stage.
package fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned INST_WIDTH       = 32;
    localparam int unsigned PC_WIDTH         = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [INST_WIDTH-1:0] instr;
    } fetch_entry_t;

    localparam int unsigned ENTRY_WIDTH = PC_WIDTH + INST_WIDTH;

    // Instruction addresses are always word aligned.
    function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
        return {pc[PC_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO with flush and occupancy count; power-of-two depth.
module fetch_queue #(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned WIDTH = 64,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && ((count_q < CNT_W'(DEPTH)) || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited memory requests, instruction queue, redirect flush.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  imem_req_valid_o,
    input  logic                  imem_req_ready_i,
    output logic [PC_WIDTH-1:0]   imem_addr_o,
    input  logic                  imem_rsp_valid_i,
    input  logic [INST_WIDTH-1:0] imem_rsp_data_i,
    input  logic                  redirect_i,
    input  logic [PC_WIDTH-1:0]   redirect_pc_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [INST_WIDTH-1:0] instruction_o,
    output logic [PC_WIDTH-1:0]   pc_o
);

    localparam int unsigned CNT_W  = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned USED_W = CNT_W + 1;
    localparam int unsigned DROP_W = 8;

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [DROP_W-1:0]   drop_q, drop_d;

    fetch_entry_t        iq_din, iq_head;
    logic [CNT_W-1:0]    iq_count;
    logic                iq_empty;
    logic                iq_push, iq_pop;

    logic [PC_WIDTH-1:0] pcq_head;
    logic [CNT_W-1:0]    inflight;

    logic [USED_W-1:0]   used;
    logic                credit;
    logic                req_fire;
    logic                rsp_keep;

    // A slot being popped this cycle is already free for a new request.
    assign used     = USED_W'(iq_count) + USED_W'(inflight) - USED_W'(iq_pop);
    assign credit   = used < USED_W'(QUEUE_DEPTH);
    assign iq_empty = (iq_count == '0);

    assign imem_req_valid_o = rst_ni && credit && !redirect_i;
    assign imem_addr_o      = pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    assign instr_valid_o = !iq_empty && !redirect_i;
    assign instruction_o = iq_empty ? '0 : iq_head.instr;
    assign pc_o          = iq_empty ? '0 : iq_head.pc;
    assign iq_pop        = instr_valid_o && instr_ready_i;

    assign rsp_keep     = imem_rsp_valid_i && (drop_q == '0) && !redirect_i;
    assign iq_push      = rsp_keep;
    assign iq_din.pc    = pcq_head;
    assign iq_din.instr = imem_rsp_data_i;

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ENTRY_WIDTH)
    ) u_instr_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (iq_push),
        .data_i  (iq_din),
        .pop_i   (iq_pop),
        .flush_i (redirect_i),
        .head_o  (iq_head),
        .count_o (iq_count)
    );

    // PCs of requests still owed a response; its occupancy is the in-flight count.
    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (PC_WIDTH)
    ) u_inflight_pc_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (req_fire),
        .data_i  (pc_q),
        .pop_i   (rsp_keep),
        .flush_i (redirect_i),
        .head_o  (pcq_head),
        .count_o (inflight)
    );

    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (redirect_i) begin
            pc_d   = align_pc(redirect_pc_i);
            drop_d = drop_q + DROP_W'(inflight) - DROP_W'(imem_rsp_valid_i);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + PC_STEP;
            end
            if (imem_rsp_valid_i && (drop_q != '0)) begin
                drop_d = drop_q - DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against an in-order memory and program-flow model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i = 1'b0;
    logic [31:0] imem_rsp_data_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;

    fetch_unit #(
        .RESET_PC    (RESET_PC),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instruction_o    (instruction_o),
        .pc_o             (pc_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Memory model: accepted addresses with the cycle their response is due.
    logic [31:0] mq_addr [$];
    int          mq_due  [$];
    int          last_due = 0;
    int          cyc = 0;

    // Program-flow model.
    logic [31:0] exp_req_pc = RESET_PC;
    logic [31:0] exp_dec_pc = RESET_PC;
    int          live = 0;
    int          n_dlv = 0;
    logic [31:0] last_dlv_pc = 32'hDEAD_BEEF;
    logic        saw_wrap = 1'b0;

    // Stimulus knobs.
    logic        k_redir = 1'b0;
    logic [31:0] k_redir_pc = '0;
    logic        k_dec_rdy = 1'b1;
    logic        k_mem_rdy = 1'b1;
    int          k_lat_min = 1;
    int          k_lat_max = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq_addr.delete();
        mq_due.delete();
        last_due   = 0;
        cyc        = 0;
        exp_req_pc = RESET_PC;
        exp_dec_pc = RESET_PC;
        live       = 0;
    endtask

    // One clock cycle: drive at negedge, check and update the model shortly after.
    task automatic step();
        logic acc;
        logic dlv;
        int   due;
        @(negedge clk_i);
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_word(mq_addr[0]);
        end
        redirect_i       = k_redir;
        redirect_pc_i    = k_redir_pc;
        instr_ready_i    = k_dec_rdy;
        imem_req_ready_i = k_mem_rdy;
        #1;
        acc = imem_req_valid_o && imem_req_ready_i;
        dlv = instr_valid_o && instr_ready_i;

        if (redirect_i) begin
            chk("redir_req_valid", 32'(imem_req_valid_o), 32'd0);
            chk("redir_instr_valid", 32'(instr_valid_o), 32'd0);
        end else begin
            chk("req_offer", 32'(imem_req_valid_o), 32'((live - int'(dlv)) < DEPTH));
        end
        if (imem_req_valid_o) chk("req_addr", imem_addr_o, exp_req_pc);
        if (dlv) begin
            chk("dlv_pc", pc_o, exp_dec_pc);
            chk("dlv_instr", instruction_o, mem_word(exp_dec_pc));
            if (pc_o == 32'h0 && last_dlv_pc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
            last_dlv_pc = pc_o;
        end

        if (imem_rsp_valid_i) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (redirect_i) begin
            exp_req_pc = {redirect_pc_i[31:2], 2'b00};
            exp_dec_pc = exp_req_pc;
            live       = 0;
        end else begin
            if (acc) begin
                due = cyc + int'($urandom_range(k_lat_max, k_lat_min));
                if (due < last_due) due = last_due;
                last_due = due;
                mq_addr.push_back(imem_addr_o);
                mq_due.push_back(due);
                exp_req_pc = exp_req_pc + 32'd4;
                live++;
            end
            if (dlv) begin
                exp_dec_pc = exp_dec_pc + 32'd4;
                live--;
                n_dlv++;
            end
        end
        chk("live_bound", 32'(live <= DEPTH), 32'd1);
        cyc++;
    endtask

    initial begin
        int n0;
        // Reset held: everything quiet.
        #3;
        chk("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instruction", instruction_o, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        model_reset();

        // Streaming from reset with single-cycle memory.
        step();
        chk("c0_req_valid", 32'(imem_req_valid_o), 32'd1);
        chk("c0_addr", imem_addr_o, RESET_PC);
        chk("c0_instr_valid", 32'(instr_valid_o), 32'd0);
        step();
        chk("c1_instr_valid", 32'(instr_valid_o), 32'd0);
        step();
        chk("c2_instr_valid", 32'(instr_valid_o), 32'd1);
        chk("c2_pc", pc_o, 32'h0);
        step();
        chk("c3_pc", pc_o, 32'h4);
        step();
        chk("c4_pc", pc_o, 32'h8);

        // Decode stall: fetch fills up and stops requesting.
        k_dec_rdy = 1'b0;
        repeat (5) step();
        chk("stall_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("stall_live", 32'(live), 32'd2);
        chk("stall_instr_valid", 32'(instr_valid_o), 32'd1);
        k_dec_rdy = 1'b1;
        repeat (6) step();

        // Redirect with responses still in flight at a slower memory.
        k_lat_min = 3; k_lat_max = 3;
        repeat (6) step();
        k_redir = 1'b1; k_redir_pc = 32'h0000_0103;
        step();
        k_redir = 1'b0;
        step();
        chk("redir_next_valid", 32'(imem_req_valid_o), 32'd1);
        chk("redir_next_addr", imem_addr_o, 32'h0000_0100);
        n0 = n_dlv;
        for (int i = 0; i < 20 && n_dlv == n0; i++) step();
        chk("redir_first_dlv", 32'(n_dlv > n0), 32'd1);
        chk("redir_first_pc", last_dlv_pc, 32'h0000_0100);

        // Redirect coinciding with decode handshake and a response.
        k_lat_min = 1; k_lat_max = 1;
        repeat (6) step();
        k_redir = 1'b1; k_redir_pc = 32'h0000_2000;
        step();
        chk("coinc_rsp", 32'(imem_rsp_valid_i), 32'd1);
        chk("coinc_instr_valid", 32'(instr_valid_o), 32'd0);
        k_redir = 1'b0;
        repeat (6) step();

        // Address wrap at the top of the space.
        k_redir = 1'b1; k_redir_pc = 32'hFFFF_FFF4;
        step();
        k_redir = 1'b0;
        repeat (10) step();
        chk("wrap_seen", 32'(saw_wrap), 32'd1);

        // Asynchronous reset with a full queue.
        k_dec_rdy = 1'b0;
        repeat (4) step();
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        chk("mid_rst_instr_valid", 32'(instr_valid_o), 32'd0);
        chk("mid_rst_instruction", instruction_o, 32'd0);
        chk("mid_rst_pc", pc_o, 32'd0);
        imem_rsp_valid_i = 1'b0;
        redirect_i = 1'b0;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        model_reset();
        k_dec_rdy = 1'b1;
        step();
        chk("restart_valid", 32'(imem_req_valid_o), 32'd1);
        chk("restart_addr", imem_addr_o, RESET_PC);
        repeat (6) step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            k_dec_rdy = ($urandom_range(3, 0) != 0);
            k_mem_rdy = ($urandom_range(9, 0) < 7);
            k_lat_min = 1;
            k_lat_max = 4;
            k_redir   = ($urandom_range(99, 0) < 3);
            k_redir_pc = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(31, 0)))
                                                     : $urandom;
            step();
        end

        // Drain with everything ready: fetch must keep making progress.
        k_redir = 1'b0; k_dec_rdy = 1'b1; k_mem_rdy = 1'b1;
        k_lat_min = 1; k_lat_max = 1;
        repeat (5) step();
        n0 = n_dlv;
        repeat (30) step();
        chk("drain_progress", 32'((n_dlv - n0) >= 25), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
